counter_4bit_sync: RTL and testbench

COUNTER_4BIT_SYNC -- requirements
Module: counter_4bit_sync

---
 rtl/counter_4bit_sync.sv | 49 ++++
 tb/tb_counter_4bit_sync.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/counter_4bit_sync.sv
// Modulo-N 4-bit up/down counter with synchronous reset, parallel load and a
// terminal-count flag (Rc) intended to drive the enable of a cascaded stage.
module counter_4bit_sync #(
  parameter int MOD_VAL   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       up,
  output logic       Qa,
  output logic       Qb,
  output logic       Qc,
  output logic       Qd,
  output logic       Rc
);

  localparam logic [3:0] QMAX = 4'(MOD_VAL - 1);
  localparam logic [3:0] QRST = 4'(RESET_VAL);
  localparam logic [4:0] MOD5 = 5'(MOD_VAL);

  logic [3:0] q, q_nxt, d_mod;
  logic [4:0] d_rem;

  // Remainder is always < MOD_VAL <= 16, so the low nibble carries it fully.
  assign d_rem = {1'b0, d} % MOD5;
  assign d_mod = d_rem[3:0];

  always_comb begin
    q_nxt = q;
    if (ld)
      q_nxt = d_mod;
    else if (en) begin
      if (up) q_nxt = (q == QMAX) ? 4'd0 : q + 4'd1;
      else    q_nxt = (q == 4'd0) ? QMAX : q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= QRST;
    else     q <= q_nxt;
  end

  assign {Qd, Qc, Qb, Qa} = q;
  assign Rc = en & (up ? (q == QMAX) : (q == 4'd0));

endmodule

// File: tb/tb_counter_4bit_sync.sv
// Directed bench: default counter, a MOD_VAL=10/RESET_VAL=7 variant, and a
// two-stage cascade chained through Rc.
module tb_counter_4bit_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic       rst, en, ld, up;
  logic [3:0] d;
  logic       qa, qb, qc, qd, rc;
  // MOD_VAL=10, RESET_VAL=7 instance
  logic       rst10, en10, ld10, up10;
  logic [3:0] d10;
  logic       qa10, qb10, qc10, qd10, rc10;
  // cascade
  logic       rstc;
  logic       qa_l, qb_l, qc_l, qd_l, rc_l;
  logic       qa_h, qb_h, qc_h, qd_h, rc_h;

  counter_4bit_sync u_dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .d(d), .up(up),
    .Qa(qa), .Qb(qb), .Qc(qc), .Qd(qd), .Rc(rc));

  counter_4bit_sync #(.MOD_VAL(10), .RESET_VAL(7)) u_m10 (
    .clk(clk), .rst(rst10), .en(en10), .ld(ld10), .d(d10), .up(up10),
    .Qa(qa10), .Qb(qb10), .Qc(qc10), .Qd(qd10), .Rc(rc10));

  counter_4bit_sync u_lo (
    .clk(clk), .rst(rstc), .en(1'b1), .ld(1'b0), .d(4'd0), .up(1'b1),
    .Qa(qa_l), .Qb(qb_l), .Qc(qc_l), .Qd(qd_l), .Rc(rc_l));

  counter_4bit_sync u_hi (
    .clk(clk), .rst(rstc), .en(rc_l), .ld(1'b0), .d(4'd0), .up(1'b1),
    .Qa(qa_h), .Qb(qb_h), .Qc(qc_h), .Qd(qd_h), .Rc(rc_h));

  wire [3:0] q   = {qd, qc, qb, qa};
  wire [3:0] q10 = {qd10, qc10, qb10, qa10};
  wire [7:0] qc8 = {qd_h, qc_h, qb_h, qa_h, qd_l, qc_l, qb_l, qa_l};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en = 1; ld = 0; up = 1; d = 4'd0;
    rst10 = 1; en10 = 1; ld10 = 0; up10 = 1; d10 = 4'd0;
    rstc = 1;

    // reset held for two edges
    step();
    chk("rst_q0", 8'(q), 8'h0); chk("rst_rc0", 8'(rc), 8'h0);
    step();
    chk("rst_q1", 8'(q), 8'h0); chk("rst_rc1", 8'(rc), 8'h0);
    rst = 0;

    // full up-count cycle, Rc only at 15
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("up_q", 8'(q), 8'(i % 16));
      chk("up_rc", 8'(rc), 8'((i % 16) == 15));
    end

    // count to 5, then hold with en=0
    for (int i = 1; i <= 5; i++) step();
    chk("q5", 8'(q), 8'h5);
    en = 0; #1;
    chk("hold_rc", 8'(rc), 8'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_q", 8'(q), 8'h5);
    end
    en = 1;
    step();
    chk("resume_q6", 8'(q), 8'h6);

    // load beats count, reset beats load
    step(); step(); step();
    chk("q9", 8'(q), 8'h9);
    ld = 1; d = 4'd3;
    step();
    chk("load_q3", 8'(q), 8'h3);
    rst = 1; d = 4'd7; #1;
    chk("rst_not_async", 8'(q), 8'h3);
    step();
    chk("rst_beats_ld", 8'(q), 8'h0);
    rst = 0; ld = 0;

    // load 2, count down through the wrap
    ld = 1; d = 4'd2;
    step();
    ld = 0; up = 0; #1;
    chk("dn_q2", 8'(q), 8'h2); chk("dn_rc2", 8'(rc), 8'h0);
    step(); chk("dn_q1", 8'(q), 8'h1); chk("dn_rc1", 8'(rc), 8'h0);
    step(); chk("dn_q0", 8'(q), 8'h0); chk("dn_rc0", 8'(rc), 8'h1);
    step(); chk("dn_q15", 8'(q), 8'hF); chk("dn_rc15", 8'(rc), 8'h0);
    step(); chk("dn_q14", 8'(q), 8'hE);
    // reversal: next enabled edge goes back up
    up = 1;
    step(); chk("rev_q15", 8'(q), 8'hF); chk("rev_rc", 8'(rc), 8'h1);
    step(); chk("rev_q0", 8'(q), 8'h0);
    // reset with up=0: Q=0 so Rc asserts
    rst = 1; up = 0;
    step(); chk("rst_dn_q", 8'(q), 8'h0); chk("rst_dn_rc", 8'(rc), 8'h1);
    rst = 0; up = 1;

    // MOD_VAL=10, RESET_VAL=7
    chk("m10_rst", 8'(q10), 8'h7);
    rst10 = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("m10_q", 8'(q10), 8'((7 + i) % 10));
      chk("m10_rc", 8'(rc10), 8'(((7 + i) % 10) == 9));
    end
    ld10 = 1; d10 = 4'd12;
    step(); chk("m10_ld12", 8'(q10), 8'h2);
    ld10 = 0; up10 = 0;
    step(); chk("m10_dn1", 8'(q10), 8'h1);
    step(); chk("m10_dn0", 8'(q10), 8'h0); chk("m10_dn_rc", 8'(rc10), 8'h1);
    step(); chk("m10_dn9", 8'(q10), 8'h9);

    // cascade: 8-bit count with wrap
    rstc = 1;
    step();
    chk("cas_rst", qc8, 8'h00);
    rstc = 0;
    for (int i = 1; i <= 258; i++) begin
      step();
      chk("cas_q", qc8, 8'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
